// File: rtl/game_pkg.sv
// Shared game constants: platform coordinates, platform index enum and BCD sizing.
package game_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_DIGITS  = 4;
  localparam int unsigned SCORE_W     = BCD_DIGIT_W * BCD_DIGITS;

  localparam logic [COORD_W-1:0] PLAT_A_X = 10'd70;
  localparam logic [COORD_W-1:0] PLAT_A_Y = 10'd116;
  localparam logic [COORD_W-1:0] PLAT_B_X = 10'd296;
  localparam logic [COORD_W-1:0] PLAT_B_Y = 10'd116;
  localparam logic [COORD_W-1:0] PLAT_C_X = 10'd180;
  localparam logic [COORD_W-1:0] PLAT_C_Y = 10'd199;

  typedef enum logic [1:0] {
    PLAT_A    = 2'd0,
    PLAT_B    = 2'd1,
    PLAT_C    = 2'd2,
    PLAT_NONE = 2'd3
  } plat_e;

  // Fallback rotation: none -> A, then A -> B -> C -> A.
  function automatic plat_e next_plat(plat_e p);
    case (p)
      PLAT_A:  return PLAT_B;
      PLAT_B:  return PLAT_C;
      default: return PLAT_A;
    endcase
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit saturating BCD incrementer; o_tick pulses the cycle after the value changes.
module bcd_counter4
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_inc,
  output logic [SCORE_W-1:0] o_bcd,
  output logic               o_tick
);

  logic [SCORE_W-1:0] r_bcd;
  logic               r_tick;
  logic [SCORE_W-1:0] w_bcd_inc;
  logic               w_sat;

  assign w_sat = (r_bcd == 16'h9999);

  // Ripple the +1 through the digits, wrapping each 9 to 0.
  always_comb begin : p_inc
    logic carry;
    carry     = 1'b1;
    w_bcd_inc = r_bcd;
    for (int d = 0; d < int'(BCD_DIGITS); d++) begin
      if (carry) begin
        if (r_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
          w_bcd_inc[d*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
        end else begin
          w_bcd_inc[d*BCD_DIGIT_W +: BCD_DIGIT_W] = r_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= i_inc & ~w_sat;
      if (i_inc && !w_sat) r_bcd <= w_bcd_inc;
    end
  end

  assign o_bcd  = r_bcd;
  assign o_tick = r_tick;

endmodule

// File: rtl/bottle_spawn_scorer.sv
// Bottle respawn responder: keeps the BCD score and offers the next spawn point
// chosen by an LFSR that never repeats the previous platform.
module bottle_spawn_scorer
  import game_pkg::*;
#(
  parameter logic [7:0]         LFSR_SEED = 8'hA5,
  parameter logic [COORD_W-1:0] A_X       = PLAT_A_X,
  parameter logic [COORD_W-1:0] A_Y       = PLAT_A_Y,
  parameter logic [COORD_W-1:0] B_X       = PLAT_B_X,
  parameter logic [COORD_W-1:0] B_Y       = PLAT_B_Y,
  parameter logic [COORD_W-1:0] C_X       = PLAT_C_X,
  parameter logic [COORD_W-1:0] C_Y       = PLAT_C_Y,
  parameter int unsigned        MAX_RETRY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_collect,
  input  logic               i_spawn_ack,
  output logic               o_spawn_valid,
  output logic [COORD_W-1:0] o_spawn_x,
  output logic [COORD_W-1:0] o_spawn_y,
  output logic [SCORE_W-1:0] o_score_bcd,
  output logic               o_score_tick
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_PICK, S_OFFER} state_e;

  state_e             r_state, w_state_next;
  logic [7:0]         r_lfsr, w_lfsr_next;
  plat_e              r_prev, w_prev_next;
  logic [RETRY_W-1:0] r_retry, w_retry_next;
  logic               r_valid, w_valid_next;
  logic [COORD_W-1:0] r_x, w_x_next;
  logic [COORD_W-1:0] r_y, w_y_next;

  logic [7:0]         w_lfsr_step;
  plat_e              w_draw_plat;
  logic [3:0]         w_draw_jit;
  logic               w_fallback;
  logic               w_accept;
  plat_e              w_sel_plat;
  logic [3:0]         w_sel_jit;
  logic [COORD_W-1:0] w_base_x;
  logic [COORD_W-1:0] w_base_y;

  // Decode the draw from the post-advance LFSR value.
  assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_draw_plat = plat_e'(w_lfsr_step[1:0]);
  assign w_draw_jit  = w_lfsr_step[5:2];
  assign w_fallback  = (r_retry == RETRY_W'(MAX_RETRY));
  assign w_accept    = (w_draw_plat != PLAT_NONE) && (w_draw_plat != r_prev);
  assign w_sel_plat  = w_fallback ? next_plat(r_prev) : w_draw_plat;
  assign w_sel_jit   = w_fallback ? 4'd0 : w_draw_jit;

  always_comb begin
    case (w_sel_plat)
      PLAT_A:  begin w_base_x = A_X; w_base_y = A_Y; end
      PLAT_B:  begin w_base_x = B_X; w_base_y = B_Y; end
      default: begin w_base_x = C_X; w_base_y = C_Y; end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_lfsr_next  = r_lfsr;
    w_prev_next  = r_prev;
    w_retry_next = r_retry;
    w_valid_next = r_valid;
    w_x_next     = r_x;
    w_y_next     = r_y;
    case (r_state)
      S_IDLE: begin
        if (i_collect) begin
          w_state_next = S_PICK;
          w_retry_next = '0;
        end
      end
      S_PICK: begin
        w_lfsr_next = w_lfsr_step;
        if (w_fallback || w_accept) begin
          w_x_next     = w_base_x + COORD_W'(w_sel_jit);
          w_y_next     = w_base_y;
          w_prev_next  = w_sel_plat;
          w_valid_next = 1'b1;
          w_state_next = S_OFFER;
        end else begin
          w_retry_next = r_retry + RETRY_W'(1);
        end
      end
      S_OFFER: begin
        if (i_spawn_ack) begin
          w_valid_next = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_prev  <= PLAT_NONE;
      r_retry <= '0;
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_next;
      r_lfsr  <= w_lfsr_next;
      r_prev  <= w_prev_next;
      r_retry <= w_retry_next;
      r_valid <= w_valid_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
    end
  end

  assign o_spawn_valid = r_valid;
  assign o_spawn_x     = r_x;
  assign o_spawn_y     = r_y;

  // Every collect scores, whatever the spawn FSM is doing.
  bcd_counter4 u_score (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (i_collect),
    .o_bcd  (o_score_bcd),
    .o_tick (o_score_tick)
  );

endmodule

// File: tb/tb_bottle_spawn_scorer.sv
// Self-checking bench for bottle_spawn_scorer against a draw-level reference model.
module tb_bottle_spawn_scorer;

  logic        clk = 1'b0;
  logic        rst;
  logic        collect, ack, valid, tick;
  logic [9:0]  sx, sy;
  logic [15:0] score;
  logic        f_collect, f_ack, f_valid, f_tick;
  logic [9:0]  f_x, f_y;
  logic [15:0] f_score;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_lfsr;
  logic [1:0] m_prev;
  int         m_score;

  always #5 clk = ~clk;

  bottle_spawn_scorer dut (
    .clk(clk), .rst(rst), .i_collect(collect), .i_spawn_ack(ack),
    .o_spawn_valid(valid), .o_spawn_x(sx), .o_spawn_y(sy),
    .o_score_bcd(score), .o_score_tick(tick)
  );

  // Seed 0x61 gives four platform-NONE draws in a row, forcing the fallback.
  bottle_spawn_scorer #(.LFSR_SEED(8'h61)) dut_fb (
    .clk(clk), .rst(rst), .i_collect(f_collect), .i_spawn_ack(f_ack),
    .o_spawn_valid(f_valid), .o_spawn_x(f_x), .o_spawn_y(f_y),
    .o_score_bcd(f_score), .o_score_tick(f_tick)
  );

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] lfsr_next(logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // One spawn decision: draws until accepted, or falls back after 4 rejections.
  function automatic void model_pick(inout logic [7:0] l, inout logic [1:0] p,
                                     output int cycles, output int x, output int y);
    int bx[3] = '{70, 296, 180};
    int by[3] = '{116, 116, 199};
    int pl = 0;
    int jit = 0;
    bit done = 1'b0;
    cycles = 0;
    for (int r = 0; r <= 4 && !done; r++) begin
      l = lfsr_next(l);
      cycles++;
      if (r == 4) begin
        pl = (p == 2'd3) ? 0 : (int'(p) + 1) % 3;
        jit = 0;
        done = 1'b1;
      end else if (l[1:0] != 2'd3 && l[1:0] != p) begin
        pl = int'(l[1:0]);
        jit = int'(l[5:2]);
        done = 1'b1;
      end
    end
    p = 2'(pl);
    x = bx[pl] + jit;
    y = by[pl];
  endfunction

  function automatic bit model_inc();
    if (m_score < 9999) begin
      m_score++;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_lfsr  = 8'hA5;
    m_prev  = 2'd3;
    m_score = 0;
  endtask

  // Collect, wait for the offer, hold it, ack it, then watch for a stray second offer.
  task automatic run_spawn(string tag, bit rnd, int hold, int inject_at, int idle,
                           output int got_x, output int got_y);
    int cyc, ex, ey, lat;
    bit et, c;
    model_pick(m_lfsr, m_prev, cyc, ex, ey);
    et = model_inc();
    collect = 1'b1;
    @(negedge clk);
    collect = 1'b0;
    n_checks++;
    if (tick !== et || score !== to_bcd(m_score)) begin
      n_fail++;
      $display("FAIL %s_collect: tick=%b score=%h, expected tick=%b score=%h",
               tag, tick, score, et, to_bcd(m_score));
    end
    lat = 1;
    while (valid !== 1'b1 && lat < 12) begin
      c = rnd && ($urandom_range(0, 1) == 1);
      collect = c;
      if (c) void'(model_inc());
      @(negedge clk);
      collect = 1'b0;
      lat++;
    end
    n_checks++;
    if (valid !== 1'b1 || lat != cyc + 1 || sx !== 10'(ex) || sy !== 10'(ey)) begin
      n_fail++;
      $display("FAIL %s_offer: valid=%b latency=%0d xy=(%0d,%0d), expected valid=1 latency=%0d xy=(%0d,%0d)",
               tag, valid, lat, sx, sy, cyc + 1, ex, ey);
    end
    got_x = int'(sx);
    got_y = int'(sy);
    for (int h = 0; h < hold; h++) begin
      c = (h == inject_at) || (rnd && $urandom_range(0, 2) == 0);
      collect = c;
      et = c ? model_inc() : 1'b0;
      @(negedge clk);
      collect = 1'b0;
      n_checks++;
      if (valid !== 1'b1 || sx !== 10'(ex) || sy !== 10'(ey) || tick !== et ||
          score !== to_bcd(m_score)) begin
        n_fail++;
        $display("FAIL %s_hold%0d: valid=%b xy=(%0d,%0d) tick=%b score=%h, expected 1 (%0d,%0d) %b %h",
                 tag, h, valid, sx, sy, tick, score, ex, ey, et, to_bcd(m_score));
      end
    end
    ack = 1'b1;
    c = rnd && ($urandom_range(0, 1) == 1);
    collect = c;
    et = c ? model_inc() : 1'b0;
    @(negedge clk);
    ack = 1'b0;
    collect = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || tick !== et || score !== to_bcd(m_score)) begin
      n_fail++;
      $display("FAIL %s_ack: valid=%b tick=%b score=%h, expected 0 %b %h",
               tag, valid, tick, score, et, to_bcd(m_score));
    end
    for (int i = 0; i < idle; i++) begin
      ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      ack = 1'b0;
      n_checks++;
      if (valid !== 1'b0 || score !== to_bcd(m_score)) begin
        n_fail++;
        $display("FAIL %s_idle%0d: valid=%b score=%h, expected 0 %h",
                 tag, i, valid, score, to_bcd(m_score));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; collect = 1'b0; ack = 1'b0; f_collect = 1'b0; f_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || sx !== 10'd0 || sy !== 10'd0 || score !== 16'h0000 ||
        tick !== 1'b0 || f_valid !== 1'b0 || f_score !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset: valid=%b xy=(%0d,%0d) score=%h tick=%b fb_valid=%b, expected all zero",
               valid, sx, sy, score, tick, f_valid);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_spawn();
    int x, y;
    run_spawn("first", 1'b0, 0, -1, 2, x, y);
    n_checks++;
    if (x != 182 || y != 199 || score !== 16'h0001) begin
      n_fail++;
      $display("FAIL first_xy: (%0d,%0d) score=%h, expected (182,199) 0001", x, y, score);
    end
  endtask

  task automatic test_second_spawn();
    int x, y;
    run_spawn("second", 1'b0, 1, -1, 2, x, y);
    n_checks++;
    if (x != 301 || y != 116 || score !== 16'h0002) begin
      n_fail++;
      $display("FAIL second_xy: (%0d,%0d) score=%h, expected (301,116) 0002", x, y, score);
    end
  endtask

  task automatic test_hold_offer();
    int x, y;
    run_spawn("hold", 1'b0, 20, 10, 6, x, y);
  endtask

  task automatic test_fallback();
    logic [7:0] l = 8'h61;
    logic [1:0] p = 2'd3;
    int cyc, ex, ey, lat;
    for (int k = 0; k < 2; k++) begin
      model_pick(l, p, cyc, ex, ey);
      f_collect = 1'b1;
      @(negedge clk);
      f_collect = 1'b0;
      lat = 1;
      while (f_valid !== 1'b1 && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (f_valid !== 1'b1 || lat != cyc + 1 || f_x !== 10'(ex) || f_y !== 10'(ey)) begin
        n_fail++;
        $display("FAIL fallback%0d: valid=%b latency=%0d xy=(%0d,%0d), expected 1 %0d (%0d,%0d)",
                 k, f_valid, lat, f_x, f_y, cyc + 1, ex, ey);
      end
      if (k == 0) begin
        n_checks++;
        if (lat != 6 || f_x !== 10'd70 || f_y !== 10'd116) begin
          n_fail++;
          $display("FAIL fallback_plat_a: latency=%0d xy=(%0d,%0d), expected 6 (70,116)",
                   lat, f_x, f_y);
        end
      end
      f_ack = 1'b1;
      @(negedge clk);
      f_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int x, y;
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_spawn($sformatf("rand%0d", i), 1'b1, $urandom_range(0, 4), -1,
                $urandom_range(1, 3), x, y);
    end
  endtask

  task automatic test_saturation();
    bit et;
    ack = 1'b1;
    while (m_score < 9998) begin
      collect = 1'b1;
      void'(model_inc());
      @(negedge clk);
    end
    collect = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (score !== 16'h9998) begin
      n_fail++;
      $display("FAIL preload: score=%h, expected 9998", score);
    end
    for (int k = 0; k < 3; k++) begin
      et = model_inc();
      collect = 1'b1;
      @(negedge clk);
      collect = 1'b0;
      n_checks++;
      if (tick !== et || score !== to_bcd(m_score)) begin
        n_fail++;
        $display("FAIL sat%0d: tick=%b score=%h, expected %b %h", k, tick, score, et, to_bcd(m_score));
      end
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_offer();
    int lat, x, y;
    collect = 1'b1;
    @(negedge clk);
    collect = 1'b0;
    lat = 1;
    while (valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_offer: valid=%b, expected 1", valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (valid !== 1'b0 || score !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b score=%h, expected 0 0000", valid, score);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_spawn("after_reset", 1'b0, 0, -1, 1, x, y);
    n_checks++;
    if (x != 182 || y != 199) begin
      n_fail++;
      $display("FAIL after_reset_xy: (%0d,%0d), expected (182,199)", x, y);
    end
  endtask

  initial begin
    test_reset();
    test_fallback();
    test_first_spawn();
    test_second_spawn();
    test_hold_offer();
    test_random();
    test_saturation();
    test_reset_mid_offer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
